// File: rtl/opcode_lookup_if.sv
// rtl/opcode_lookup_if.sv - opcode memory read port: address, read strobe, registered read data
interface opcode_lookup_if #(
    parameter int ADDR_BITS = 13
) ();
    logic [ADDR_BITS-1:0] MemAddr;
    logic                 MemRd;
    logic [7:0]           MemData;

    // master: the lookup engine; slave: the opcode memory
    modport master (output MemAddr, output MemRd, input MemData);
    modport slave  (input MemAddr, input MemRd, output MemData);
endinterface

// File: rtl/opcode_lookup.sv
// rtl/opcode_lookup.sv - reverse lookup of a typed mnemonic against 32-byte slots in opcode memory
module opcode_lookup #(
    parameter int MAX_TOK   = 8,
    parameter int SLOT_BITS = 8,
    parameter int OFS_BITS  = 5
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [7:0]           i_TokChar,
    input  logic                 i_TokWr,
    input  logic                 i_TokClr,
    input  logic                 i_Start,
    opcode_lookup_if.master      mem,
    output logic                 o_Busy,
    output logic                 o_Done,
    output logic                 o_Found,
    output logic [SLOT_BITS-1:0] o_Opcode,
    output logic                 o_TokErr
);
    localparam int LEN_BITS = $clog2(MAX_TOK + 1);
    localparam int IDX_BITS = (MAX_TOK > 1) ? $clog2(MAX_TOK) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CMP, S_DONE} state_t;

    state_t                        r_state;
    logic [7:0]                    r_tok [MAX_TOK];
    logic [LEN_BITS-1:0]           r_len;
    logic [SLOT_BITS-1:0]          r_slot;
    logic [OFS_BITS-1:0]           r_ofs;
    logic [SLOT_BITS+OFS_BITS-1:0] r_mem_addr;
    logic                          r_mem_rd;
    logic                          r_busy;
    logic                          r_done;
    logic                          r_found;
    logic [SLOT_BITS-1:0]          r_opcode;
    logic                          r_tok_err;

    logic                          w_at_term;
    logic [7:0]                    w_exp_byte;
    logic                          w_byte_eq;
    logic                          w_tok_full;
    logic                          w_last_slot;
    logic [7:0]                    w_fold_char;

    assign mem.MemAddr = r_mem_addr;
    assign mem.MemRd   = r_mem_rd;
    assign o_Busy      = r_busy;
    assign o_Done      = r_done;
    assign o_Found     = r_found;
    assign o_Opcode    = r_opcode;
    assign o_TokErr    = r_tok_err;

    // Once ofs reaches len the slot must hold the terminator, so "add" never matches "adds".
    assign w_at_term   = (r_ofs == OFS_BITS'(r_len));
    assign w_exp_byte  = w_at_term ? 8'h00 : r_tok[r_ofs[IDX_BITS-1:0]];
    assign w_byte_eq   = (mem.MemData == w_exp_byte);
    assign w_tok_full  = (r_len == LEN_BITS'(MAX_TOK));
    assign w_last_slot = (r_slot == {SLOT_BITS{1'b1}});
    assign w_fold_char = ((i_TokChar >= 8'h41) && (i_TokChar <= 8'h5A)) ? (i_TokChar + 8'h20) : i_TokChar;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state    <= S_IDLE;
            for (int i = 0; i < MAX_TOK; i++) r_tok[i] <= 8'h00;
            r_len      <= '0;
            r_slot     <= '0;
            r_ofs      <= '0;
            r_mem_addr <= '0;
            r_mem_rd   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_found    <= 1'b0;
            r_opcode   <= '0;
            r_tok_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (i_Start) begin
                        r_found  <= 1'b0;
                        r_opcode <= '0;
                        r_slot   <= '0;
                        r_ofs    <= '0;
                        if ((r_len == '0) || r_tok_err) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= S_ISSUE;
                            r_busy     <= 1'b1;
                            r_mem_rd   <= 1'b1;
                            r_mem_addr <= '0;
                        end
                    end else if (i_TokClr) begin
                        r_len     <= '0;
                        r_tok_err <= 1'b0;
                    end else if (i_TokWr) begin
                        if (w_tok_full) begin
                            r_tok_err <= 1'b1;
                        end else begin
                            r_tok[r_len[IDX_BITS-1:0]] <= w_fold_char;
                            r_len                      <= r_len + LEN_BITS'(1);
                        end
                    end
                end
                S_ISSUE: begin
                    r_mem_rd <= 1'b0;
                    r_state  <= S_CMP;
                end
                S_CMP: begin
                    if (w_byte_eq && !w_at_term) begin
                        r_ofs      <= r_ofs + OFS_BITS'(1);
                        r_mem_addr <= {r_slot, r_ofs + OFS_BITS'(1)};
                        r_mem_rd   <= 1'b1;
                        r_state    <= S_ISSUE;
                    end else if (w_byte_eq) begin
                        r_found  <= 1'b1;
                        r_opcode <= r_slot;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else if (!w_last_slot) begin
                        // first differing byte abandons the slot; the rest of it is never read
                        r_slot     <= r_slot + SLOT_BITS'(1);
                        r_ofs      <= '0;
                        r_mem_addr <= {r_slot + SLOT_BITS'(1), {OFS_BITS{1'b0}}};
                        r_mem_rd   <= 1'b1;
                        r_state    <= S_ISSUE;
                    end else begin
                        r_found  <= 1'b0;
                        r_opcode <= '0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_opcode_lookup.sv
// tb/tb_opcode_lookup.sv - scoreboard bench for opcode_lookup with a string-level reference model
module tb_opcode_lookup;
    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic [7:0] TokChar = 8'h00;
    logic       TokWr = 1'b0;
    logic       TokClr = 1'b0;
    logic       Start = 1'b0;
    logic       Busy, Done, Found, TokErr;
    logic [7:0] Opcode;

    always #5 Clk = ~Clk;

    opcode_lookup_if mem_if ();

    opcode_lookup dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .i_TokChar (TokChar),
        .i_TokWr   (TokWr),
        .i_TokClr  (TokClr),
        .i_Start   (Start),
        .mem       (mem_if),
        .o_Busy    (Busy),
        .o_Done    (Done),
        .o_Found   (Found),
        .o_Opcode  (Opcode),
        .o_TokErr  (TokErr)
    );

    logic [7:0] mem [8192];

    always @(posedge Clk) begin
        if (Rst) mem_if.MemData <= 8'h00;
        else if (mem_if.MemRd) mem_if.MemData <= mem[mem_if.MemAddr];
    end

    typedef struct {
        bit found;
        int opcode;
        int reads;
        int last_addr;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         done_cnt = 0;
    logic [7:0] m_tok [8];
    int         m_len = 0;
    bit         m_err = 0;

    function automatic void check(string nm, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endfunction

    function automatic string slot_str(int s);
        string r = "";
        for (int i = 0; i < 32; i++) begin
            if (mem[s*32+i] == 8'h00) break;
            r = $sformatf("%s%c", r, mem[s*32+i]);
        end
        return r;
    endfunction

    function automatic string tok_str();
        string r = "";
        for (int i = 0; i < m_len; i++) r = $sformatf("%s%c", r, m_tok[i]);
        return r;
    endfunction

    // Reference: first slot whose NUL-terminated string equals the folded token; each slot costs
    // (common prefix + 1) reads, the +1 being the byte that differs or the matching terminator.
    function automatic exp_t model();
        exp_t  e;
        string t;
        string ss;
        int    p;
        e.found = 0; e.opcode = 0; e.reads = 0; e.last_addr = -1;
        if (m_len == 0 || m_err) return e;
        t = tok_str();
        for (int s = 0; s < 256; s++) begin
            ss = slot_str(s);
            p = 0;
            while (p < t.len() && p < ss.len() && t[p] == ss[p]) p++;
            e.reads += p + 1;
            e.last_addr = s * 32 + p;
            if (ss == t) begin
                e.found = 1;
                e.opcode = s;
                return e;
            end
        end
        return e;
    endfunction

    task automatic put_slot(int s, string str);
        for (int i = 0; i < 32; i++) mem[s*32+i] = 8'h00;
        for (int i = 0; i < str.len(); i++) mem[s*32+i] = str[i];
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic tok_put(logic [7:0] c);
        TokChar = c;
        TokWr = 1'b1;
        tick();
        TokWr = 1'b0;
        if (m_len == 8) m_err = 1;
        else begin
            m_tok[m_len] = (c >= 8'h41 && c <= 8'h5A) ? c + 8'h20 : c;
            m_len++;
        end
    endtask

    task automatic write_tok(string s);
        TokClr = 1'b1;
        tick();
        TokClr = 1'b0;
        m_len = 0;
        m_err = 0;
        for (int i = 0; i < s.len(); i++) tok_put(s[i]);
        check($sformatf("tokerr[%s]", s), int'(TokErr), int'(m_err));
    endtask

    task automatic wait_done(string nm, int prev);
        int t = 0;
        while (done_cnt == prev && t < 4000) begin
            tick();
            t++;
        end
        if (done_cnt == prev) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout[%s]: got no Done, expected Done within 4000 cycles", nm);
            sb.delete();
        end
        tick();
    endtask

    task automatic lookup(string nm);
        int prev;
        sb.push_back(model());
        prev = done_cnt;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        wait_done(nm, prev);
    endtask

    // Monitor: latency counted in rising edges from the Start edge to the edge that raises Done
    bit   trk = 0;
    int   cnt, rds, last;
    exp_t me;

    always @(negedge Clk) begin
        if (Rst) begin
            trk = 0;
        end else if (trk) begin
            cnt++;
            if (mem_if.MemRd) begin
                rds++;
                last = int'(mem_if.MemAddr);
            end
            if (Done) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL done_unexpected: got Done, expected no pending lookup");
                end else begin
                    me = sb.pop_front();
                    check("found", int'(Found), int'(me.found));
                    check("opcode", int'(Opcode), me.opcode);
                    check("reads", rds, me.reads);
                    check("latency", cnt, 2 * me.reads);
                    check("busy_at_done", int'(Busy), 0);
                    if (me.reads > 0) check("last_addr", last, me.last_addr);
                end
                trk = 0;
                done_cnt++;
            end
        end else begin
            if (Done) begin
                n_cmp++;
                n_err++;
                $display("FAIL done_stray: got Done=1, expected 0 outside a lookup");
            end
            if (mem_if.MemRd) begin
                n_cmp++;
                n_err++;
                $display("FAIL memrd_stray: got MemRd=1, expected 0 outside a lookup");
            end
            if (Start) begin
                trk = 1;
                cnt = -1;
                rds = 0;
                last = -1;
            end
        end
    end

    task automatic rand_tok(input string alpha, input int lo, input int hi, output string s);
        int n = $urandom_range(hi, lo);
        s = "";
        for (int i = 0; i < n; i++) s = $sformatf("%s%c", s, alpha[$urandom_range(alpha.len() - 1, 0)]);
    endtask

    initial begin
        string names[6];
        string s;
        string w;
        int    prev;
        int    slot;
        logic [7:0] c;

        names[0] = "add"; names[1] = "adds"; names[2] = "sub";
        names[3] = "or"; names[4] = "jal"; names[5] = "label";
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        put_slot(0, "add"); put_slot(1, "adds"); put_slot(2, "sub"); put_slot(9, "or");
        put_slot(8'h30, "MUL"); put_slot(8'h31, "mul"); put_slot(8'h49, "jal"); put_slot(8'h84, "label");
        for (int i = 0; i < 40; i++) begin
            slot = $urandom_range(255, 10);
            if (mem[slot*32] == 8'h00) begin
                rand_tok("bcdeg", 1, 4, w);
                put_slot(slot, w);
            end
        end

        tick();
        tick();
        check("rst_busy", int'(Busy), 0);
        check("rst_done", int'(Done), 0);
        check("rst_found", int'(Found), 0);
        check("rst_opcode", int'(Opcode), 0);
        check("rst_tokerr", int'(TokErr), 0);
        check("rst_memrd", int'(mem_if.MemRd), 0);
        Rst = 1'b0;
        tick();

        write_tok("add");   lookup("add");
        write_tok("sub");   lookup("sub");
        write_tok("adds");  lookup("adds");
        write_tok("ADD");   lookup("ADD");
        write_tok("label"); lookup("label");
        write_tok("or");    lookup("or");
        write_tok("jal");   lookup("jal");
        write_tok("MUL");   lookup("MUL");
        lookup("MUL repeat");
        write_tok("foo");   lookup("foo");
        write_tok("abcdefghi");
        lookup("overflow");
        write_tok("");      lookup("empty");

        // TokWr and Start during a scan must leave the buffer untouched
        write_tok("sub");
        sb.push_back(model());
        prev = done_cnt;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        TokChar = 8'h78;
        TokWr = 1'b1;
        Start = 1'b1;
        tick();
        TokWr = 1'b0;
        Start = 1'b0;
        check("busy_in_scan", int'(Busy), 1);
        wait_done("sub busy", prev);
        lookup("sub after busy writes");

        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(3, 0))
                0: rand_tok("bcdegBCDEG", 1, 4, s);
                1: begin
                    w = names[$urandom_range(5, 0)];
                    s = "";
                    for (int k = 0; k < w.len(); k++) begin
                        c = w[k];
                        if ($urandom_range(1, 0) == 1) c = c - 8'h20;
                        s = $sformatf("%s%c", s, c);
                    end
                end
                2: rand_tok("abcdefgh", 9, 10, s);
                default: rand_tok("bcdeg", 1, 8, s);
            endcase
            write_tok(s);
            lookup(s);
        end

        // reset in the middle of a full-table scan
        write_tok("foo");
        Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (40) tick();
        Rst = 1'b1;
        #1;
        check("midrst_busy", int'(Busy), 0);
        check("midrst_memrd", int'(mem_if.MemRd), 0);
        check("midrst_done", int'(Done), 0);
        check("midrst_found", int'(Found), 0);
        tick();
        tick();
        Rst = 1'b0;
        m_len = 0;
        m_err = 0;
        tick();
        check("midrst_tokerr", int'(TokErr), 0);
        lookup("empty after reset");
        write_tok("or");
        lookup("or after reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
